// File: rtl/aib_txfifo_pkg.sv
// Shared types and helpers for the TX FIFO read-side controller.
// Contents: FSM state enum, gearbox mode enum, FIFO geometry, gray/binary conversion,
//   and the dwords-per-entry lookup for each gearbox mode.
package aib_txfifo_pkg;

  localparam int DEPTH  = 16;               // FIFO entries (power of 2)
  localparam int DEPTH4 = DEPTH * 4;        // 80b dword selectors
  localparam int AWIDTH = $clog2(DEPTH);    // entry address bits
  localparam int PW     = AWIDTH + 1;       // pointer width incl. wrap bit
  localparam int IW     = AWIDTH + 2;       // dword index width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    READ = 2'd2
  } aib_txfifo_rd_st_e;

  typedef enum logic [1:0] {
    MODE_1DW  = 2'b00,
    MODE_2DW  = 2'b01,
    MODE_4DW  = 2'b10,
    MODE_RSVD = 2'b11
  } aib_txfifo_mode_e;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Reserved mode behaves as the 4-dword gearbox.
  function automatic logic [2:0] dw_per_entry(input aib_txfifo_mode_e m);
    case (m)
      MODE_1DW: return 3'd1;
      MODE_2DW: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/aib_txfifo_rd_ctrl_if.sv
// Bus between the TX FIFO read controller and its adapter/datapath.
// master: the read controller (drives fifo_rd_en and status).
// slave : adapter config + datapath side (drives config and synchronized write pointer).
interface aib_txfifo_rd_ctrl_if;
  import aib_txfifo_pkg::*;

  logic              rd_enable;
  logic [1:0]        fifo_mode;
  logic [PW-1:0]     rd_start_lvl;
  logic [PW-1:0]     wr_ptr_gray_sync;
  logic              underflow_clr;

  logic [DEPTH4-1:0] fifo_rd_en;
  logic              rd_valid;
  logic [PW-1:0]     rd_ptr_gray;
  logic [PW-1:0]     fifo_level;
  logic              fifo_empty;
  logic              fifo_underflow;
  logic              rd_active;

  modport master (
    input  rd_enable, fifo_mode, rd_start_lvl, wr_ptr_gray_sync, underflow_clr,
    output fifo_rd_en, rd_valid, rd_ptr_gray, fifo_level, fifo_empty, fifo_underflow, rd_active
  );

  modport slave (
    output rd_enable, fifo_mode, rd_start_lvl, wr_ptr_gray_sync, underflow_clr,
    input  fifo_rd_en, rd_valid, rd_ptr_gray, fifo_level, fifo_empty, fifo_underflow, rd_active
  );

endinterface

// File: rtl/aib_txfifo_rd_ptr.sv
// Read pointer bookkeeping: binary issue pointer, released gray pointer, occupancy.
// Latency: level_o combinational from pointers; rd_ptr_gray_o / fifo_level_o registered.
// Ports: issue_inc_i advances the entry pointer; wr_ptr_gray_sync_i is the synchronized write ptr.
module aib_txfifo_rd_ptr
  import aib_txfifo_pkg::*;
(
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              issue_inc_i,
  input  logic [PW-1:0]     wr_ptr_gray_sync_i,
  output logic [AWIDTH-1:0] issue_addr_o,
  output logic [PW-1:0]     level_o,
  output logic [PW-1:0]     rd_ptr_gray_o,
  output logic [PW-1:0]     fifo_level_o,
  output logic              fifo_empty_o
);

  logic [PW-1:0] issue_ptr_q, issue_ptr_d;
  logic [PW-1:0] rel_gray_q;
  logic [PW-1:0] fifo_level_q;
  logic          fifo_empty_q;

  assign issue_ptr_d  = issue_inc_i ? issue_ptr_q + PW'(1) : issue_ptr_q;
  assign level_o      = gray2bin(wr_ptr_gray_sync_i) - issue_ptr_q;
  assign issue_addr_o = issue_ptr_q[AWIDTH-1:0];

  // The released pointer is the issue pointer one cycle late, so the writer only
  // sees an entry freed after its last dword select has already been registered.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      issue_ptr_q  <= '0;
      rel_gray_q   <= '0;
      fifo_level_q <= '0;
      fifo_empty_q <= 1'b1;
    end else begin
      issue_ptr_q  <= issue_ptr_d;
      rel_gray_q   <= bin2gray(issue_ptr_q);
      fifo_level_q <= level_o;
      fifo_empty_q <= (level_o == '0);
    end
  end

  assign rd_ptr_gray_o = rel_gray_q;
  assign fifo_level_o  = fifo_level_q;
  assign fifo_empty_o  = fifo_empty_q;

endmodule

// File: rtl/aib_txfifo_rd_ctrl.sv
// TX FIFO read controller: one-hot dword select sequencing 1/2/4 dwords per entry.
// Latency: decision cycle t -> fifo_rd_en at t+1 -> rd_valid at t+2 (aligned with read data).
// Backpressure: none downstream; starts on fill threshold, stalls and flags underflow when empty.
// Ports: rd_clk, rd_rst (sync, active-high), bus (master side of aib_txfifo_rd_ctrl_if).
module aib_txfifo_rd_ctrl
  import aib_txfifo_pkg::*;
(
  input  logic               rd_clk,
  input  logic               rd_rst,
  aib_txfifo_rd_ctrl_if.master bus
);

  aib_txfifo_rd_st_e  state_q;
  aib_txfifo_mode_e   mode_q;
  logic [1:0]         sub_q;
  logic [DEPTH4-1:0]  fifo_rd_en_q;
  logic               rd_valid_q;
  logic               underflow_q;

  logic [AWIDTH-1:0]  issue_addr;
  logic [PW-1:0]      level;
  logic [PW-1:0]      start_lvl;
  logic [IW-1:0]      idx;
  logic               in_read, stop_now, issue, starve, last_sub, issue_inc;

  // Threshold of 0 would start on an empty FIFO; beyond DEPTH would never start.
  always_comb begin
    start_lvl = bus.rd_start_lvl;
    if (bus.rd_start_lvl == '0) begin
      start_lvl = PW'(1);
    end else if (bus.rd_start_lvl > PW'(DEPTH)) begin
      start_lvl = PW'(DEPTH);
    end
  end

  assign idx       = {issue_addr, sub_q};
  assign last_sub  = ({1'b0, sub_q} == (dw_per_entry(mode_q) - 3'd1));
  assign in_read   = (state_q == READ);
  // A disable only takes effect on an entry boundary; mid-entry dwords are always finished.
  assign stop_now  = in_read && !bus.rd_enable && (sub_q == 2'd0);
  // Level is only checked at sub 0: the whole entry was counted when its first dword issued.
  assign issue     = in_read && !stop_now && ((sub_q != 2'd0) || (level != '0));
  assign starve    = in_read && !stop_now && (sub_q == 2'd0) && (level == '0);
  assign issue_inc = issue && last_sub;

  aib_txfifo_rd_ptr u_rd_ptr (
    .rd_clk             (rd_clk),
    .rd_rst             (rd_rst),
    .issue_inc_i        (issue_inc),
    .wr_ptr_gray_sync_i (bus.wr_ptr_gray_sync),
    .issue_addr_o       (issue_addr),
    .level_o            (level),
    .rd_ptr_gray_o      (bus.rd_ptr_gray),
    .fifo_level_o       (bus.fifo_level),
    .fifo_empty_o       (bus.fifo_empty)
  );

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_4DW;
      sub_q        <= 2'd0;
      fifo_rd_en_q <= '0;
      rd_valid_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      fifo_rd_en_q <= '0;
      rd_valid_q   <= |fifo_rd_en_q;
      // A new underflow beats a simultaneous clear.
      underflow_q  <= starve || (underflow_q && !bus.underflow_clr);
      case (state_q)
        IDLE: begin
          if (bus.rd_enable) begin
            mode_q  <= aib_txfifo_mode_e'(bus.fifo_mode);
            state_q <= FILL;
          end
        end
        FILL: begin
          if (!bus.rd_enable) begin
            state_q <= IDLE;
          end else if (level >= start_lvl) begin
            state_q <= READ;
          end
        end
        READ: begin
          if (stop_now) begin
            state_q <= IDLE;
          end else if (issue) begin
            fifo_rd_en_q[idx] <= 1'b1;
            if (last_sub) begin
              sub_q <= 2'd0;
              if (!bus.rd_enable) begin
                state_q <= IDLE;
              end
            end else begin
              sub_q <= sub_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en     = fifo_rd_en_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.fifo_underflow = underflow_q;
  assign bus.rd_active      = (state_q == READ);

endmodule
